// File: rtl/rf_write_arbiter_pkg.sv
// Shared widths and the queued-write entry type for the register-file write arbiter.
package rf_write_arbiter_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] w;
        logic [DATA_W-1:0] data;
    } wq_entry_t;

endpackage

// File: rtl/rf_write_arbiter_wq_fifo.sv
// Circular queue of multiply/divide results awaiting the register-file write port.
// The squash compare port exists only when RF_WAW_SQUASH_EN is defined.
module rf_wq_fifo
    import rf_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [ADDR_W-1:0]      push_w_i,
    input  logic [DATA_W-1:0]      push_data_i,
    input  logic                   pop_i,
    input  logic [DEPTH-1:0]       inv_i,
    input  logic [ADDR_W-1:0]      cmp_a_i,
    input  logic [ADDR_W-1:0]      cmp_b_i,
`ifdef RF_WAW_SQUASH_EN
    input  logic [ADDR_W-1:0]      cmp_c_i,
    output logic [DEPTH-1:0]       match_c_o,
`endif
    output logic                   head_valid_o,
    output logic [ADDR_W-1:0]      head_w_o,
    output logic [DATA_W-1:0]      head_data_o,
    output logic [DEPTH-1:0]       head_oh_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [DEPTH-1:0]       match_a_o,
    output logic [DEPTH-1:0]       match_b_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1'b1);

    wq_entry_t        mem_q [DEPTH];
    wq_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    // Next state: invalidate first, pop clears the head slot, push fills the tail slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (inv_i[i]) begin
                mem_d[i].valid = 1'b0;
            end else begin
                mem_d[i].valid = mem_q[i].valid;
            end
        end
        if (pop_i) begin
            mem_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d              = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_i) begin
            mem_d[wr_ptr_q] = '{valid: 1'b1, w: push_w_i, data: push_data_i};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{valid: 1'b0, w: {ADDR_W{1'b0}}, data: {DATA_W{1'b0}}};
            end
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W+1){1'b0}};
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head view and per-slot compares; a cleared valid bit covers both empty and squashed slots.
    always_comb begin
        head_valid_o = mem_q[rd_ptr_q].valid;
        head_w_o     = mem_q[rd_ptr_q].w;
        head_data_o  = mem_q[rd_ptr_q].data;
        count_o      = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            head_oh_o[i] = (rd_ptr_q == PTR_W'(i));
            match_a_o[i] = mem_q[i].valid && (mem_q[i].w == cmp_a_i);
            match_b_o[i] = mem_q[i].valid && (mem_q[i].w == cmp_b_i);
`ifdef RF_WAW_SQUASH_EN
            match_c_o[i] = mem_q[i].valid && (mem_q[i].w == cmp_c_i);
`endif
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write port arbiter: WB pipeline writes versus queued multiply/divide results.
// Define RF_WAW_SQUASH_EN to let a performed pipeline write squash older queued writes to the same register.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_we_i,
    input  logic [ADDR_W-1:0] pipe_w_i,
    input  logic [DATA_W-1:0] pipe_data_i,
    input  logic              md_valid_i,
    input  logic [ADDR_W-1:0] md_w_i,
    input  logic [DATA_W-1:0] md_data_i,
    output logic              md_ready_o,
    output logic              pipe_stall_o,
    input  logic [ADDR_W-1:0] rd_a_i,
    input  logic [ADDR_W-1:0] rd_b_i,
    output logic              hazard_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_w_o,
    output logic [DATA_W-1:0] rf_data_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [PTR_W:0]  CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [SC_W-1:0] SC_MAX   = SC_W'(STARVE_LIMIT);
    localparam logic [SC_W-1:0] SC_ONE   = SC_W'(1'b1);

    logic              pipe_req_s, nonempty_s, head_live_s, head_dead_s;
    logic              forced_s, md_write_s, pop_s, push_s, md_fire_s;
    logic              head_valid_s, haz_a_s, haz_b_s;
    logic [ADDR_W-1:0] head_w_s;
    logic [DATA_W-1:0] head_data_s;
    logic [DEPTH-1:0]  head_oh_s, match_a_s, match_b_s, inv_s, pop_mask_s;
    logic [PTR_W:0]    count_s;
    logic [SC_W-1:0]   starve_q, starve_d;
`ifdef RF_WAW_SQUASH_EN
    logic              pipe_write_s;
    logic [DEPTH-1:0]  match_c_s;
`endif

    rf_wq_fifo #(.DEPTH(DEPTH)) u_wq (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push_s),
        .push_w_i     (md_w_i),
        .push_data_i  (md_data_i),
        .pop_i        (pop_s),
        .inv_i        (inv_s),
        .cmp_a_i      (rd_a_i),
        .cmp_b_i      (rd_b_i),
`ifdef RF_WAW_SQUASH_EN
        .cmp_c_i      (pipe_w_i),
        .match_c_o    (match_c_s),
`endif
        .head_valid_o (head_valid_s),
        .head_w_o     (head_w_s),
        .head_data_o  (head_data_s),
        .head_oh_o    (head_oh_s),
        .count_o      (count_s),
        .match_a_o    (match_a_s),
        .match_b_o    (match_b_s)
    );

    // Port ownership: forced drain beats the pipeline, which beats an opportunistic drain.
    always_comb begin
        pipe_req_s   = pipe_we_i && (pipe_w_i != 5'd0);
        nonempty_s   = (count_s != {(PTR_W+1){1'b0}});
        head_live_s  = nonempty_s && head_valid_s;
        head_dead_s  = nonempty_s && !head_valid_s;
        forced_s     = head_live_s && (starve_q == SC_MAX);
        md_write_s   = forced_s || (head_live_s && !pipe_req_s);
        pop_s        = md_write_s || head_dead_s;
        md_ready_o   = (count_s < CNT_FULL);
        pipe_stall_o = forced_s && pipe_req_s;
        md_fire_s    = md_valid_i && md_ready_o && (md_w_i != 5'd0);
`ifdef RF_WAW_SQUASH_EN
        pipe_write_s = pipe_req_s && !forced_s;
        push_s       = md_fire_s && !(pipe_write_s && (md_w_i == pipe_w_i));
        inv_s        = pipe_write_s ? match_c_s : {DEPTH{1'b0}};
`else
        push_s       = md_fire_s;
        inv_s        = {DEPTH{1'b0}};
`endif
        if (md_write_s) begin
            rf_we_o   = 1'b1;
            rf_w_o    = head_w_s;
            rf_data_o = head_data_s;
        end else begin
            rf_we_o   = pipe_req_s;
            rf_w_o    = pipe_w_i;
            rf_data_o = pipe_data_i;
        end
        // The entry leaving this cycle and the register being written are both bypassed.
        pop_mask_s = pop_s ? head_oh_s : {DEPTH{1'b0}};
        haz_a_s    = (rd_a_i != 5'd0) && (|(match_a_s & ~pop_mask_s))
                     && !(rf_we_o && (rf_w_o == rd_a_i));
        haz_b_s    = (rd_b_i != 5'd0) && (|(match_b_s & ~pop_mask_s))
                     && !(rf_we_o && (rf_w_o == rd_b_i));
        hazard_o   = haz_a_s || haz_b_s;
    end

    // Starvation counter: counts cycles a live head waits behind pipeline writes.
    always_comb begin
        if (pop_s || !nonempty_s) begin
            starve_d = {SC_W{1'b0}};
        end else if (starve_q != SC_MAX) begin
            starve_d = starve_q + SC_ONE;
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= {SC_W{1'b0}};
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_rf_write_arbiter;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;
`ifdef RF_WAW_SQUASH_EN
    localparam bit SQUASH = 1'b1;
`else
    localparam bit SQUASH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we, md_valid;
    logic [4:0]  pipe_w, md_w, rd_a, rd_b;
    logic [31:0] pipe_data, md_data;
    logic        md_ready, pipe_stall, hazard, rf_we;
    logic [4:0]  rf_w;
    logic [31:0] rf_data;
    logic [31:0] tb_rf [32];
    int          n_checks = 0;
    int          n_fail   = 0;

    rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_we_i(pipe_we), .pipe_w_i(pipe_w), .pipe_data_i(pipe_data),
        .md_valid_i(md_valid), .md_w_i(md_w), .md_data_i(md_data), .md_ready_o(md_ready),
        .pipe_stall_o(pipe_stall), .rd_a_i(rd_a), .rd_b_i(rd_b), .hazard_o(hazard),
        .rf_we_o(rf_we), .rf_w_o(rf_w), .rf_data_o(rf_data)
    );

    always #5 clk = ~clk;

    // Architectural register file written from the arbiter's port.
    always @(posedge clk) begin
        if (rf_we) tb_rf[rf_w] <= rf_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pwe, input logic [4:0] pw, input logic [31:0] pd,
                         input logic mv, input logic [4:0] mw, input logic [31:0] md,
                         input logic [4:0] ra, input logic [4:0] rb);
        pipe_we = pwe; pipe_w = pw; pipe_data = pd;
        md_valid = mv; md_w = mw; md_data = md;
        rd_a = ra; rd_b = rb;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- reference model: ordered queue of pending writes ----------------
    typedef struct {
        logic [4:0]  w;
        logic [31:0] d;
        bit          live;
    } ment_t;
    ment_t       mq[$];
    int          m_starve;
    logic        e_we, e_stall, e_haz, e_rdy;
    logic [4:0]  e_w;
    logic [31:0] e_d;
    bit          e_pop, e_pipe_done;

    function automatic bit pend(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (e_we && e_w == r) return 1'b0;
        for (int k = 0; k < mq.size(); k++) begin
            if (!(k == 0 && e_pop) && mq[k].live && mq[k].w == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_eval();
        bit preq, has, live_head, forced, mdw;
        preq      = pipe_we && (pipe_w != 5'd0);
        has       = (mq.size() > 0);
        live_head = has && mq[0].live;
        forced    = live_head && (m_starve == STARVE_LIMIT);
        mdw       = forced || (live_head && !preq);
        e_pop     = mdw || (has && !mq[0].live);
        e_pipe_done = preq && !forced;
        e_we      = mdw ? 1'b1 : preq;
        e_w       = mdw ? mq[0].w : pipe_w;
        e_d       = mdw ? mq[0].d : pipe_data;
        e_stall   = forced && preq;
        e_rdy     = (mq.size() < DEPTH);
        e_haz     = pend(rd_a) || pend(rd_b);
    endtask

    task automatic model_commit();
        bit    push;
        ment_t e;
        push = md_valid && e_rdy && (md_w != 5'd0);
        if (SQUASH && e_pipe_done && md_w == pipe_w) push = 1'b0;
        if (e_pop || mq.size() == 0) m_starve = 0;
        else if (m_starve < STARVE_LIMIT) m_starve++;
        if (e_pop) void'(mq.pop_front());
        if (SQUASH && e_pipe_done) begin
            foreach (mq[k]) if (mq[k].w == pipe_w) mq[k].live = 1'b0;
        end
        if (push) begin
            e.w = md_w; e.d = md_data; e.live = 1'b1;
            mq.push_back(e);
        end
    endtask

    // ---------------- single-cycle vector table ----------------
    typedef struct {
        logic        pre;  logic [4:0] pre_w; logic [31:0] pre_d;
        logic        pwe;  logic [4:0] pw;    logic [31:0] pd;
        logic        mv;   logic [4:0] mw;
        logic [4:0]  ra;   logic [4:0] rb;
        logic        e_we; logic [4:0] e_w;   logic [31:0] e_d;
        logic        e_stall, e_haz, e_rdy;
    } vec_t;
    vec_t vecs[10];

    initial begin
        logic [4:0]  ow [3];
        logic [31:0] od [3];

        vecs[0] = '{1'b0,5'd0,32'h0,  1'b1,5'd3,32'h33, 1'b0,5'd0, 5'd0,5'd0, 1'b1,5'd3,32'h33, 1'b0,1'b0,1'b1};
        vecs[1] = '{1'b0,5'd0,32'h0,  1'b1,5'd0,32'h44, 1'b0,5'd0, 5'd0,5'd0, 1'b0,5'd0,32'h44, 1'b0,1'b0,1'b1};
        vecs[2] = '{1'b0,5'd0,32'h0,  1'b0,5'd6,32'h66, 1'b0,5'd0, 5'd0,5'd0, 1'b0,5'd6,32'h66, 1'b0,1'b0,1'b1};
        vecs[3] = '{1'b1,5'd9,32'h99, 1'b0,5'd0,32'h0,  1'b0,5'd0, 5'd9,5'd0, 1'b1,5'd9,32'h99, 1'b0,1'b0,1'b1};
        vecs[4] = '{1'b1,5'd9,32'h99, 1'b1,5'd2,32'h22, 1'b0,5'd0, 5'd9,5'd0, 1'b1,5'd2,32'h22, 1'b0,1'b1,1'b1};
        vecs[5] = '{1'b1,5'd9,32'h99, 1'b1,5'd2,32'h22, 1'b0,5'd0, 5'd0,5'd9, 1'b1,5'd2,32'h22, 1'b0,1'b1,1'b1};
        vecs[6] = '{1'b1,5'd9,32'h99, 1'b1,5'd2,32'h22, 1'b0,5'd0, 5'd0,5'd0, 1'b1,5'd2,32'h22, 1'b0,1'b0,1'b1};
        vecs[7] = '{1'b1,5'd9,32'h99, 1'b1,5'd9,32'h55, 1'b0,5'd0, 5'd9,5'd0, 1'b1,5'd9,32'h55, 1'b0,1'b0,1'b1};
        vecs[8] = '{1'b1,5'd9,32'h99, 1'b1,5'd2,32'h22, 1'b0,5'd0, 5'd8,5'd0, 1'b1,5'd2,32'h22, 1'b0,1'b0,1'b1};
        vecs[9] = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b1,5'd5, 5'd5,5'd0, 1'b0,5'd0,32'h0,  1'b0,1'b0,1'b1};

        // Reset values; rf_* follow the pipe inputs while in reset.
        rst = 1'b0;
        drive(1'b1, 5'd3, 32'h1234, 1'b1, 5'd5, 32'h5, 5'd5, 5'd5);
        #1 rst = 1'b1;
        #1;
        check("reset_md_ready", md_ready, 1'b1);
        check("reset_stall", pipe_stall, 1'b0);
        check("reset_hazard", hazard, 1'b0);
        check("reset_rf_we", rf_we, 1'b1);
        check("reset_rf_w", rf_w, 5'd3);
        check("reset_rf_data", rf_data, 32'h1234);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            if (vecs[i].pre) begin
                drive(1'b1, 5'd1, 32'h1, 1'b1, vecs[i].pre_w, vecs[i].pre_d, 5'd0, 5'd0);
                next_cycle();
            end
            drive(vecs[i].pwe, vecs[i].pw, vecs[i].pd, vecs[i].mv, vecs[i].mw, 32'h0,
                  vecs[i].ra, vecs[i].rb);
            @(negedge clk);
            check($sformatf("vec%0d_rf_we", i), rf_we, vecs[i].e_we);
            check($sformatf("vec%0d_rf_w", i), rf_w, vecs[i].e_w);
            check($sformatf("vec%0d_rf_data", i), rf_data, vecs[i].e_d);
            check($sformatf("vec%0d_stall", i), pipe_stall, vecs[i].e_stall);
            check($sformatf("vec%0d_hazard", i), hazard, vecs[i].e_haz);
            check($sformatf("vec%0d_md_ready", i), md_ready, vecs[i].e_rdy);
            next_cycle();
        end

        // MD result accepted at an edge is written in the following cycle.
        do_reset();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h11, 5'd0, 5'd0);
        @(negedge clk);
        check("md_lat_pre_we", rf_we, 1'b0);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        check("md_lat_we", rf_we, 1'b1);
        check("md_lat_w", rf_w, 5'd5);
        check("md_lat_data", rf_data, 32'h11);
        next_cycle();
        @(negedge clk);
        check("md_lat_empty_we", rf_we, 1'b0);
        check("md_lat_empty_ready", md_ready, 1'b1);
        next_cycle();

        // Forced drain under continuous pipeline writes.
        do_reset();
        drive(1'b1, 5'd3, 32'h300, 1'b1, 5'd7, 32'h77, 5'd0, 5'd0);
        next_cycle();
        drive(1'b1, 5'd3, 32'h300, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int c = 1; c <= STARVE_LIMIT; c++) begin
            @(negedge clk);
            check($sformatf("starve_wait%0d_w", c), rf_w, 5'd3);
            check($sformatf("starve_wait%0d_stall", c), pipe_stall, 1'b0);
            next_cycle();
        end
        @(negedge clk);
        check("forced_w", rf_w, 5'd7);
        check("forced_data", rf_data, 32'h77);
        check("forced_stall", pipe_stall, 1'b1);
        next_cycle();
        @(negedge clk);
        check("after_forced_w", rf_w, 5'd3);
        check("after_forced_we", rf_we, 1'b1);
        check("after_forced_stall", pipe_stall, 1'b0);
        next_cycle();

        // Fill, back-pressure, simultaneous push/pop, order preservation.
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b1, 5'd1, 32'h1, 1'b1, 5'(11 + k), 32'hC0 + k, 5'd0, 5'd0);
            next_cycle();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd15, 32'hD5, 5'd0, 5'd0);
        @(negedge clk);
        check("full_ready", md_ready, 1'b0);
        check("full_pop_w", rf_w, 5'd11);
        check("full_pop_data", rf_data, 32'hC0);
        next_cycle();
        @(negedge clk);
        check("pushpop_ready", md_ready, 1'b1);
        check("pushpop_w", rf_w, 5'd12);
        next_cycle();
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd16, 32'hD6, 5'd0, 5'd0);
        @(negedge clk);
        check("refill_ready", md_ready, 1'b1);
        check("refill_pipe_w", rf_w, 5'd1);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        check("refull_ready", md_ready, 1'b0);
        check("drain0_w", rf_w, 5'd13);
        next_cycle();
        ow[0] = 5'd14; ow[1] = 5'd15; ow[2] = 5'd16;
        od[0] = 32'hC3; od[1] = 32'hD5; od[2] = 32'hD6;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("drain%0d_w", k + 1), rf_w, ow[k]);
            check($sformatf("drain%0d_data", k + 1), rf_data, od[k]);
            check($sformatf("drain%0d_ready", k + 1), md_ready, 1'b1);
            next_cycle();
        end
        @(negedge clk);
        check("drained_we", rf_we, 1'b0);
        next_cycle();

        // MD result to r0 is discarded.
        do_reset();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hEE, 5'd0, 5'd0);
        @(negedge clk);
        check("md_r0_ready", md_ready, 1'b1);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        check("md_r0_we", rf_we, 1'b0);
        next_cycle();

        // WAW between a queued result and a younger pipeline write.
        do_reset();
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd4, 32'hAA, 5'd0, 5'd0);
        next_cycle();
        drive(1'b1, 5'd4, 32'hBB, 1'b0, 5'd0, 32'h0, 5'd4, 5'd0);
        @(negedge clk);
        check("waw_pipe_w", rf_w, 5'd4);
        check("waw_pipe_data", rf_data, 32'hBB);
        check("waw_bypass_hazard", hazard, 1'b0);
        next_cycle();
        drive(1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 32'h0, 5'd4, 5'd0);
        @(negedge clk);
        check("waw_after_hazard", hazard, SQUASH ? 1'b0 : 1'b1);
        check("waw_after_w", rf_w, 5'd2);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd0);
        @(negedge clk);
        check("waw_drain_we", rf_we, SQUASH ? 1'b0 : 1'b1);
        check("waw_drain_w", rf_w, SQUASH ? 5'd0 : 5'd4);
        check("waw_drain_data", rf_data, SQUASH ? 32'h0 : 32'hAA);
        check("waw_drain_hazard", hazard, 1'b0);
        next_cycle();
        @(negedge clk);
        check("waw_r4_final", tb_rf[4], SQUASH ? 32'hBB : 32'hAA);
        next_cycle();

        // Randomized traffic against the reference model, with one mid-run reset.
        do_reset();
        mq.delete();
        m_starve = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit busy;
            if (cyc == 2000) begin
                do_reset();
                mq.delete();
                m_starve = 0;
            end
            busy = ((cyc / 150) % 2) == 1;
            drive(busy ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            model_eval();
            @(negedge clk);
            check("rnd_rf_we", rf_we, e_we);
            check("rnd_rf_w", rf_w, e_w);
            check("rnd_rf_data", rf_data, e_d);
            check("rnd_stall", pipe_stall, e_stall);
            check("rnd_hazard", hazard, e_haz);
            check("rnd_md_ready", md_ready, e_rdy);
            model_commit();
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
